regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised successor to the CPU register file: XLEN-wide, REG_COUNT-deep, two read ports and one write port, with the same strobe/ack handshake. Adds a post-reset hardware clear sequence with a ready flag, one-deep holding of strobes, read indices captured at strobe time, and a selectable same-cycle write-to-read bypass. Sits between the decode/execute and writeback stages of the core.

Parameters:
XLEN, 32, register width in bits
REG_COUNT, 32, number of registers; power of 2, at least 2
BYPASS, 0, 0 = write has priority and a colliding read is deferred one cycle; 1 = read and write both serviced in the same cycle with forwarding
ZERO_REG, 1, 1 = index 0 is hardwired to zero; 0 = index 0 is an ordinary register
(localparam RIDX_W = $clog2(REG_COUNT))

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
ready_o  out  1  high once the clear sequence has finished
stb_read_i  in  1  read request, one-cycle pulse
op_rs1_i  in  RIDX_W  first read index
op_rs2_i  in  RIDX_W  second read index
ack_read_o  out  1  one-cycle pulse; reg_rs1_o/reg_rs2_o are valid
reg_rs1_o  out  XLEN  first read value; held until the next read ack
reg_rs2_o  out  XLEN  second read value; held until the next read ack
stb_write_i  in  1  write request, one-cycle pulse
op_rd_i  in  RIDX_W  write index
reg_rd_i  in  XLEN  write data
ack_write_o  out  1  one-cycle pulse; write committed

Behaviour:
- Reset (rst_i high at a posedge): ack_read_o=0, ack_write_o=0, ready_o=0, reg_rs1_o=0, reg_rs2_o=0, pending flags cleared, clear counter=0, state=S_CLEAR. Reset mid-operation discards all pending requests and restarts the clear sequence.
- S_CLEAR: writes 0 to cpu_reg[cnt] each cycle, cnt 0..REG_COUNT-1, taking REG_COUNT cycles.
  - After the last index: state=S_IDLE, and ready_o rises the following cycle.
  - Strobes during S_CLEAR are captured into holding slots (see below) and are not acked until S_IDLE.
- Holding slots: one read slot (rs1, rs2) and one write slot (rd, data), each with a pending flag.
  - Indices and data are captured on the strobe cycle; later input changes are ignored.
  - A second strobe of the same kind before its ack overwrites the slot (last wins); a single ack is produced.
- S_IDLE servicing, per cycle, over live strobes plus pending slots:
  - Write only: commit; ack_write_o=1 next cycle.
  - Read only: data registered; ack_read_o=1 next cycle (latency 1).
  - Read and write together, BYPASS=0: write serviced first; read held pending and serviced the next cycle (ack_read_o 2 cycles after the strobe); read sees the new value.
  - Read and write together, BYPASS=1: both acks next cycle. Any rs index equal to rd receives reg_rd data, except rd=0 when ZERO_REG=1.
- ZERO_REG=1:
  - Write to index 0 is dropped but still acked.
  - Read of index 0 returns 0 regardless of array contents.
- Ack pulses are exactly one cycle wide. A pending slot clears in the cycle it is serviced.
- No internal event can stall a service cycle in S_IDLE. Worst-case latency for a deferred read is 2 cycles.

Decomposition:
- Package regfile_pkg:
  - state enum {S_CLEAR, S_IDLE};
  - default XLEN and REG_COUNT constants;
  - typedef struct for the read slot {rs1, rs2} and the write slot {rd, data}, parametrised via the package defaults.
- Single module, no sub-module. Storage array inline with the syn_ramstyle="block_ram" attribute; the bypass mux lives in the read path.

Test Plan:
- Reset, then hold idle; count cycles -> ready_o rises exactly REG_COUNT+1 cycles after rst_i falls (33 for the default). Read x5 afterwards returns 0.
- Read strobe during S_CLEAR (rs1=3, rs2=4), with indices changed the next cycle -> one ack_read_o in the first S_IDLE cycle carrying regs 3 and 4 (both 0).
- BYPASS=0: write x7=0xDEADBEEF and read rs1=7 on the same cycle -> ack_write_o at +1; ack_read_o at +2 with reg_rs1_o=0xDEADBEEF.
- BYPASS=1, same stimulus -> ack_write_o and ack_read_o both at +1, reg_rs1_o=0xDEADBEEF.
- ZERO_REG=1: write x0=0x12345678 -> acked; subsequent read rs1=0 returns 0.
- Assert rst_i while a read is pending -> no ack, outputs return to 0, clear restarts, and ready_o returns REG_COUNT+1 cycles after rst_i falls.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the multi-port register file
//
// Purpose: state encoding of the register file controller, default geometry,
// and the holding-slot layouts for the default geometry.
// Ports: none (package).

package regfile_pkg;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   localparam int XLEN_DEF      = 32;
   localparam int REG_COUNT_DEF = 32;
   localparam int RIDX_W_DEF    = $clog2(REG_COUNT_DEF);

   // Read holding slot: both source indices captured together on the strobe.
   typedef struct packed {
      logic [RIDX_W_DEF-1:0] rs1;
      logic [RIDX_W_DEF-1:0] rs2;
   } rd_slot_t;

   // Write holding slot: destination index and data captured on the strobe.
   typedef struct packed {
      logic [RIDX_W_DEF-1:0] rd;
      logic [XLEN_DEF-1:0]   data;
   } wr_slot_t;

endpackage

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-read / one-write register file with clear sequence and strobe holding
//
// Purpose: XLEN x REG_COUNT register file between decode/execute and writeback.
// After reset every entry is cleared by hardware (one entry per cycle) before
// ready_o rises. Strobes are captured into one-deep holding slots so a request
// arriving during the clear, or deferred by a write collision, is never lost.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   ready_o                      clear sequence finished
//   stb_read_i, op_rs1_i/op_rs2_i read request and indices
//   ack_read_o, reg_rs1_o/rs2_o  read acknowledge and held read data
//   stb_write_i, op_rd_i, reg_rd_i write request, index and data
//   ack_write_o                  write committed

module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int REG_COUNT = REG_COUNT_DEF,
   parameter int BYPASS    = 0,
   parameter int ZERO_REG  = 1,
   localparam int RIDX_W   = $clog2(REG_COUNT)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              ready_o,
   input  logic              stb_read_i,
   input  logic [RIDX_W-1:0] op_rs1_i,
   input  logic [RIDX_W-1:0] op_rs2_i,
   output logic              ack_read_o,
   output logic [XLEN-1:0]   reg_rs1_o,
   output logic [XLEN-1:0]   reg_rs2_o,
   input  logic              stb_write_i,
   input  logic [RIDX_W-1:0] op_rd_i,
   input  logic [XLEN-1:0]   reg_rd_i,
   output logic              ack_write_o
);

   // Slot layouts sized by this instance's parameters.
   typedef struct packed {
      logic [RIDX_W-1:0] rs1;
      logic [RIDX_W-1:0] rs2;
   } rslot_t;

   typedef struct packed {
      logic [RIDX_W-1:0] rd;
      logic [XLEN-1:0]   data;
   } wslot_t;

   (* syn_ramstyle = "block_ram" *) logic [XLEN-1:0] cpu_reg [REG_COUNT];

   state_t            state_q, state_d;
   logic [RIDX_W-1:0] cnt_q;

   rslot_t rslot_q, rd_eff;
   wslot_t wslot_q, wr_eff;
   logic   rd_pend_q, wr_pend_q;
   logic   rd_defer_q;

   logic   rd_req, wr_req;
   logic   do_read, do_write, defer_read, wr_drop;

   logic              mem_we;
   logic [RIDX_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [XLEN-1:0]   rs1_val, rs2_val;

   function automatic logic [XLEN-1:0] read_port(input logic [RIDX_W-1:0] idx);
      if ((ZERO_REG != 0) && (idx == '0))
         return '0;
      return cpu_reg[idx];
   endfunction

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= S_CLEAR;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR: if (cnt_q == RIDX_W'(REG_COUNT - 1)) state_d = S_IDLE;
         S_IDLE:  state_d = S_IDLE;
         default: state_d = S_CLEAR;
      endcase
   end

   // ---------------- service decision ----------------
   always_comb begin
      rd_req = stb_read_i | rd_pend_q;
      wr_req = stb_write_i | wr_pend_q;

      // A live strobe always supersedes the slot (last request wins).
      rd_eff = rslot_q;
      if (stb_read_i) begin
         rd_eff.rs1 = op_rs1_i;
         rd_eff.rs2 = op_rs2_i;
      end
      wr_eff = wslot_q;
      if (stb_write_i) begin
         wr_eff.rd   = op_rd_i;
         wr_eff.data = reg_rd_i;
      end

      do_read    = 1'b0;
      do_write   = 1'b0;
      defer_read = 1'b0;
      if (state_q == S_IDLE) begin
         if (BYPASS != 0) begin
            do_read  = rd_req;
            do_write = wr_req;
         end else if (rd_defer_q) begin
            // A read already pushed back once goes first so its latency stays
            // bounded at two cycles; any write waits in its slot.
            do_read = 1'b1;
         end else begin
            do_write   = wr_req;
            do_read    = rd_req & ~wr_req;
            defer_read = rd_req & wr_req;
         end
      end

      wr_drop = (ZERO_REG != 0) && (wr_eff.rd == '0);

      // Single array write port shared by the clear sequence and commits.
      if (state_q == S_CLEAR) begin
         mem_we    = ~rst_i;
         mem_addr  = cnt_q;
         mem_wdata = '0;
      end else begin
         mem_we    = do_write & ~wr_drop & ~rst_i;
         mem_addr  = wr_eff.rd;
         mem_wdata = wr_eff.data;
      end

      // Read path with optional same-cycle forwarding of the committing write.
      rs1_val = read_port(rd_eff.rs1);
      rs2_val = read_port(rd_eff.rs2);
      if ((BYPASS != 0) && do_write && !wr_drop) begin
         if (rd_eff.rs1 == wr_eff.rd) rs1_val = wr_eff.data;
         if (rd_eff.rs2 == wr_eff.rd) rs2_val = wr_eff.data;
      end
   end

   // ---------------- storage ----------------
   always_ff @(posedge clk_i) begin
      if (mem_we)
         cpu_reg[mem_addr] <= mem_wdata;
   end

   // ---------------- control and outputs ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         ready_o     <= 1'b0;
         ack_read_o  <= 1'b0;
         ack_write_o <= 1'b0;
         reg_rs1_o   <= '0;
         reg_rs2_o   <= '0;
         rslot_q     <= '0;
         wslot_q     <= '0;
         rd_pend_q   <= 1'b0;
         wr_pend_q   <= 1'b0;
         rd_defer_q  <= 1'b0;
      end else begin
         if (state_q == S_CLEAR)
            cnt_q <= cnt_q + 1'b1;
         ready_o     <= (state_q == S_IDLE);
         ack_read_o  <= do_read;
         ack_write_o <= do_write;
         if (do_read) begin
            reg_rs1_o <= rs1_val;
            reg_rs2_o <= rs2_val;
         end
         if (stb_read_i)
            rslot_q <= rd_eff;
         if (stb_write_i)
            wslot_q <= wr_eff;
         rd_pend_q  <= rd_req & ~do_read;
         wr_pend_q  <= wr_req & ~do_write;
         rd_defer_q <= defer_read;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp, deferring and bypassing variants side by side

module tb_regfile_mp;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb_read = 1'b0, stb_write = 1'b0;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
   logic [31:0] wdata = '0;

   logic        a_ready, a_ack_read, a_ack_write;
   logic [31:0] a_rs1, a_rs2;
   logic        b_ready, b_ack_read, b_ack_write;
   logic [31:0] b_rs1, b_rs2;

   regfile_mp #(.BYPASS(0)) dut_a (
      .clk_i(clk), .rst_i(rst), .ready_o(a_ready),
      .stb_read_i(stb_read), .op_rs1_i(rs1), .op_rs2_i(rs2),
      .ack_read_o(a_ack_read), .reg_rs1_o(a_rs1), .reg_rs2_o(a_rs2),
      .stb_write_i(stb_write), .op_rd_i(rd), .reg_rd_i(wdata),
      .ack_write_o(a_ack_write));

   regfile_mp #(.BYPASS(1)) dut_b (
      .clk_i(clk), .rst_i(rst), .ready_o(b_ready),
      .stb_read_i(stb_read), .op_rs1_i(rs1), .op_rs2_i(rs2),
      .ack_read_o(b_ack_read), .reg_rs1_o(b_rs1), .reg_rs2_o(b_rs2),
      .stb_write_i(stb_write), .op_rd_i(rd), .reg_rd_i(wdata),
      .ack_write_o(b_ack_write));

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] v1; logic [31:0] v2; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] model [32];
   int          errors = 0;
   int          checks = 0;
   int          ar_n = 0, aw_n = 0, br_n = 0, bw_n = 0;

   always @(negedge clk) begin
      if (a_ack_read)  ar_n++;
      if (a_ack_write) aw_n++;
      if (b_ack_read)  br_n++;
      if (b_ack_write) bw_n++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear;
      for (int i = 0; i < 32; i++) model[i] = '0;
      exp_q.delete();
   endtask

   function automatic logic [31:0] mval(input logic [4:0] i);
      return (i == 5'd0) ? 32'h0 : model[i];
   endfunction

   function automatic exp_t pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   task automatic write_req(input logic [4:0] idx, input logic [31:0] d);
      stb_write = 1'b1; rd = idx; wdata = d;
      if (idx != 5'd0) model[idx] = d;
   endtask

   task automatic read_req(input logic [4:0] i1, input logic [4:0] i2);
      stb_read = 1'b1; rs1 = i1; rs2 = i2;
      exp_q.push_back({mval(i1), mval(i2)});
   endtask

   // Runs five cycles after a strobe, deasserting strobes after the first edge,
   // and records the first ack of each kind per instance (-1 if none).
   task automatic observe(output int lra, output int lrb, output int lwa, output int lwb,
                          output logic [31:0] ra1, output logic [31:0] ra2,
                          output logic [31:0] rb1, output logic [31:0] rb2);
      lra = -1; lrb = -1; lwa = -1; lwb = -1;
      ra1 = 'x; ra2 = 'x; rb1 = 'x; rb2 = 'x;
      for (int i = 1; i <= 5; i++) begin
         tick;
         if (i == 1) begin stb_read = 1'b0; stb_write = 1'b0; end
         if (a_ack_read && lra < 0)  begin lra = i; ra1 = a_rs1; ra2 = a_rs2; end
         if (b_ack_read && lrb < 0)  begin lrb = i; rb1 = b_rs1; rb2 = b_rs2; end
         if (a_ack_write && lwa < 0) lwa = i;
         if (b_ack_write && lwb < 0) lwb = i;
      end
   endtask

   task automatic test_reset;
      int na, nb;
      rst = 1'b1; stb_read = 1'b0; stb_write = 1'b0;
      tick; tick;
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
      checks++; if (a_ack_read !== 1'b0) begin errors++; $display("FAIL reset_ack_read: got %b expected 0", a_ack_read); end
      checks++; if (a_ack_write !== 1'b0) begin errors++; $display("FAIL reset_ack_write: got %b expected 0", a_ack_write); end
      checks++; if ({a_rs1, a_rs2} !== 64'h0) begin errors++; $display("FAIL reset_rs: got %h %h expected 0 0", a_rs1, a_rs2); end
      checks++; if ({b_ready, b_ack_read, b_ack_write, b_rs1, b_rs2} !== 67'h0) begin errors++; $display("FAIL reset_b_outputs: got %b%b%b %h %h expected all 0", b_ready, b_ack_read, b_ack_write, b_rs1, b_rs2); end
      rst = 1'b0;
      model_clear();
      na = -1; nb = -1;
      for (int i = 1; i <= 60 && (na < 0 || nb < 0); i++) begin
         tick;
         if (a_ready && na < 0) na = i;
         if (b_ready && nb < 0) nb = i;
      end
      checks++; if (na != 33) begin errors++; $display("FAIL ready_latency_a: got %0d cycles expected 33", na); end
      checks++; if (nb != 33) begin errors++; $display("FAIL ready_latency_b: got %0d cycles expected 33", nb); end
   endtask

   task automatic test_read_x5;
      int lra, lrb, lwa, lwb, n0;
      logic [31:0] ra1, ra2, rb1, rb2;
      exp_t e;
      n0 = ar_n;
      read_req(5, 5);
      observe(lra, lrb, lwa, lwb, ra1, ra2, rb1, rb2);
      e = pop_exp();
      checks++; if (lra != 1 || lrb != 1) begin errors++; $display("FAIL read_x5_latency: got %0d/%0d expected 1/1", lra, lrb); end
      checks++; if ({ra1, ra2, rb1, rb2} !== {e.v1, e.v2, e.v1, e.v2}) begin errors++; $display("FAIL read_x5_data: got %h %h %h %h expected %h", ra1, ra2, rb1, rb2, e.v1); end
      checks++; if (ar_n - n0 != 1) begin errors++; $display("FAIL read_x5_ack_width: got %0d ack cycles expected 1", ar_n - n0); end
   endtask

   task automatic test_write_read;
      wr_slot_t pat [4];
      int lra, lrb, lwa, lwb;
      logic [31:0] ra1, ra2, rb1, rb2;
      exp_t e;
      pat[0] = {5'd3, $urandom()}; pat[1] = {5'd4, $urandom()};
      pat[2] = {5'd12, 32'hFFFF_FFFF}; pat[3] = {5'd31, 32'h0000_0001};
      foreach (pat[k]) begin
         write_req(pat[k].rd, pat[k].data);
         observe(lra, lrb, lwa, lwb, ra1, ra2, rb1, rb2);
         checks++; if (lwa != 1 || lwb != 1 || lra != -1) begin errors++; $display("FAIL write_ack_%0d: got w%0d/w%0d r%0d expected w1/w1 r-1", k, lwa, lwb, lra); end
      end
      for (int k = 0; k < 4; k += 2) begin
         read_req(pat[k].rd, pat[k+1].rd);
         observe(lra, lrb, lwa, lwb, ra1, ra2, rb1, rb2);
         e = pop_exp();
         checks++; if (lra != 1 || {ra1, ra2} !== {e.v1, e.v2}) begin errors++; $display("FAIL readback_a_%0d: got lat %0d %h %h expected lat 1 %h %h", k, lra, ra1, ra2, e.v1, e.v2); end
         checks++; if (lrb != 1 || {rb1, rb2} !== {e.v1, e.v2}) begin errors++; $display("FAIL readback_b_%0d: got lat %0d %h %h expected lat 1 %h %h", k, lrb, rb1, rb2, e.v1, e.v2); end
      end
   endtask

   task automatic test_read_during_clear;
      int t, nr, la, lb, a0, b0;
      logic [31:0] ra1, ra2, rb1, rb2;
      exp_t e;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      model_clear();
      a0 = ar_n; b0 = br_n;
      stb_read = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
      tick;
      read_req(3, 4);
      tick;
      stb_read = 1'b0; rs1 = 5'd5; rs2 = 5'd6;
      t = 2; nr = -1; la = -1; lb = -1;
      ra1 = 'x; ra2 = 'x; rb1 = 'x; rb2 = 'x;
      while (t < 60 && (nr < 0 || la < 0 || lb < 0)) begin
         tick; t++;
         if (a_ready && nr < 0) nr = t;
         if (a_ack_read && la < 0) begin la = t; ra1 = a_rs1; ra2 = a_rs2; end
         if (b_ack_read && lb < 0) begin lb = t; rb1 = b_rs1; rb2 = b_rs2; end
      end
      tick; tick;
      e = pop_exp();
      checks++; if (nr != 33) begin errors++; $display("FAIL clear_ready: got %0d expected 33", nr); end
      checks++; if (la != nr || lb != nr) begin errors++; $display("FAIL clear_read_ack_time: got %0d/%0d expected %0d", la, lb, nr); end
      checks++; if (ar_n - a0 != 1 || br_n - b0 != 1) begin errors++; $display("FAIL clear_read_ack_count: got %0d/%0d expected 1/1", ar_n - a0, br_n - b0); end
      checks++; if ({ra1, ra2, rb1, rb2} !== {e.v1, e.v2, e.v1, e.v2}) begin errors++; $display("FAIL clear_read_data: got %h %h %h %h expected 0", ra1, ra2, rb1, rb2); end
   endtask

   task automatic test_collision;
      int lra, lrb, lwa, lwb;
      logic [31:0] ra1, ra2, rb1, rb2;
      exp_t e;
      write_req(7, 32'hDEAD_BEEF);
      read_req(7, 3);
      observe(lra, lrb, lwa, lwb, ra1, ra2, rb1, rb2);
      e = pop_exp();
      checks++; if (lwa != 1 || lra != 2) begin errors++; $display("FAIL collision_a_timing: got w%0d r%0d expected w1 r2", lwa, lra); end
      checks++; if (lwb != 1 || lrb != 1) begin errors++; $display("FAIL collision_b_timing: got w%0d r%0d expected w1 r1", lwb, lrb); end
      checks++; if (ra1 !== 32'hDEAD_BEEF || rb1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL collision_rs1: got %h/%h expected deadbeef", ra1, rb1); end
      checks++; if (ra2 !== e.v2 || rb2 !== e.v2) begin errors++; $display("FAIL collision_rs2: got %h/%h expected %h", ra2, rb2, e.v2); end
      write_req(3, 32'hCAFE_F00D);
      read_req(7, 3);
      observe(lra, lrb, lwa, lwb, ra1, ra2, rb1, rb2);
      e = pop_exp();
      checks++; if ({ra1, ra2} !== {e.v1, e.v2} || lra != 2) begin errors++; $display("FAIL collision2_a: got lat %0d %h %h expected lat 2 %h %h", lra, ra1, ra2, e.v1, e.v2); end
      checks++; if ({rb1, rb2} !== {e.v1, e.v2} || lrb != 1) begin errors++; $display("FAIL collision2_b: got lat %0d %h %h expected lat 1 %h %h", lrb, rb1, rb2, e.v1, e.v2); end
   endtask

   task automatic test_zero_reg;
      int lra, lrb, lwa, lwb;
      logic [31:0] ra1, ra2, rb1, rb2;
      exp_t e;
      write_req(0, 32'h1234_5678);
      observe(lra, lrb, lwa, lwb, ra1, ra2, rb1, rb2);
      checks++; if (lwa != 1 || lwb != 1) begin errors++; $display("FAIL zero_write_ack: got %0d/%0d expected 1/1", lwa, lwb); end
      read_req(0, 0);
      observe(lra, lrb, lwa, lwb, ra1, ra2, rb1, rb2);
      e = pop_exp();
      checks++; if ({ra1, ra2, rb1, rb2} !== {e.v1, e.v2, e.v1, e.v2} || lra != 1) begin errors++; $display("FAIL zero_read: got %h %h %h %h expected 0", ra1, ra2, rb1, rb2); end
      write_req(0, 32'hAAAA_5555);
      read_req(0, 7);
      observe(lra, lrb, lwa, lwb, ra1, ra2, rb1, rb2);
      e = pop_exp();
      checks++; if ({rb1, rb2} !== {e.v1, e.v2} || {ra1, ra2} !== {e.v1, e.v2}) begin errors++; $display("FAIL zero_no_forward: got %h %h / %h %h expected %h %h", ra1, ra2, rb1, rb2, e.v1, e.v2); end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      read_req(3, 4);
      tick;
      read_req(7, 12);
      e = pop_exp();
      checks++; if (a_ack_read !== 1'b1 || {a_rs1, a_rs2} !== {e.v1, e.v2}) begin errors++; $display("FAIL b2b_first_a: got ack %b %h %h expected ack 1 %h %h", a_ack_read, a_rs1, a_rs2, e.v1, e.v2); end
      checks++; if (b_ack_read !== 1'b1 || {b_rs1, b_rs2} !== {e.v1, e.v2}) begin errors++; $display("FAIL b2b_first_b: got ack %b %h %h expected ack 1 %h %h", b_ack_read, b_rs1, b_rs2, e.v1, e.v2); end
      tick;
      stb_read = 1'b0;
      e = pop_exp();
      checks++; if (a_ack_read !== 1'b1 || {a_rs1, a_rs2} !== {e.v1, e.v2}) begin errors++; $display("FAIL b2b_second_a: got ack %b %h %h expected ack 1 %h %h", a_ack_read, a_rs1, a_rs2, e.v1, e.v2); end
      checks++; if (b_ack_read !== 1'b1 || {b_rs1, b_rs2} !== {e.v1, e.v2}) begin errors++; $display("FAIL b2b_second_b: got ack %b %h %h expected ack 1 %h %h", b_ack_read, b_rs1, b_rs2, e.v1, e.v2); end
      tick;
      checks++; if (a_ack_read !== 1'b0 || b_ack_read !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop: got %b/%b expected 0/0", a_ack_read, b_ack_read); end
   endtask

   task automatic test_reset_pending;
      int t, nr, a0, aw0, bw0, lra, lrb, lwa, lwb;
      logic [31:0] ra1, ra2, rb1, rb2;
      exp_t e;
      write_req(7, 32'h0000_0055);
      read_req(7, 1);
      tick;
      stb_read = 1'b0; stb_write = 1'b0;
      e = pop_exp();
      checks++; if (a_ack_write !== 1'b1 || a_ack_read !== 1'b0) begin errors++; $display("FAIL pend_setup_a: got w%b r%b expected w1 r0", a_ack_write, a_ack_read); end
      checks++; if (b_ack_read !== 1'b1 || b_rs1 !== e.v1) begin errors++; $display("FAIL pend_setup_b: got r%b %h expected r1 %h", b_ack_read, b_rs1, e.v1); end
      rst = 1'b1;
      tick;
      a0 = ar_n;
      checks++; if ({a_ready, a_ack_read, a_rs1, a_rs2} !== 66'h0) begin errors++; $display("FAIL pend_reset_a: got %b %b %h %h expected 0", a_ready, a_ack_read, a_rs1, a_rs2); end
      checks++; if ({b_ready, b_rs1, b_rs2} !== 65'h0) begin errors++; $display("FAIL pend_reset_b: got %b %h %h expected 0", b_ready, b_rs1, b_rs2); end
      rst = 1'b0;
      model_clear();
      aw0 = aw_n; bw0 = bw_n;
      stb_write = 1'b1; rd = 5'd9; wdata = 32'h1;
      tick;
      rd = 5'd10; wdata = 32'h2;
      model[10] = 32'h2;
      tick;
      stb_write = 1'b0; rd = 5'd11; wdata = 32'h3;
      t = 2; nr = -1;
      while (t < 60 && nr < 0) begin
         tick; t++;
         if (a_ready) nr = t;
      end
      tick; tick;
      checks++; if (nr != 33) begin errors++; $display("FAIL pend_ready: got %0d expected 33", nr); end
      checks++; if (ar_n - a0 != 0) begin errors++; $display("FAIL pend_discarded: got %0d read acks expected 0", ar_n - a0); end
      checks++; if (aw_n - aw0 != 1 || bw_n - bw0 != 1) begin errors++; $display("FAIL pend_write_single_ack: got %0d/%0d expected 1/1", aw_n - aw0, bw_n - bw0); end
      read_req(9, 10);
      observe(lra, lrb, lwa, lwb, ra1, ra2, rb1, rb2);
      e = pop_exp();
      checks++; if ({ra1, ra2, rb1, rb2} !== {e.v1, e.v2, e.v1, e.v2} || lra != 1) begin errors++; $display("FAIL pend_last_wins: got %h %h %h %h expected %h %h", ra1, ra2, rb1, rb2, e.v1, e.v2); end
   endtask

   initial begin
      test_reset;
      test_read_x5;
      test_write_read;
      test_collision;
      test_zero_reg;
      test_back_to_back;
      test_reset_pending;
      test_read_during_clear;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
